// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode, ALU-function and FSM-state definitions for the
// multi-cycle cpu_ctrl sequencer and its PC sub-module.
package cpu_ctrl_pkg;

    localparam int OP_W  = 4;
    localparam int REG_W = 2;
    localparam int IMM_W = 8;
    localparam int RET_W = 16;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_LDI  = 4'h5,
        OP_JMP  = 4'h6,
        OP_JZ   = 4'h7,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_AND   = 3'd2,
        ALU_OR    = 3'd3,
        ALU_PASSB = 3'd4
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs;
        logic [IMM_W-1:0] imm;
    } ir_t;

    // Unassigned encodings collapse to NOP here, so nothing downstream
    // ever sees an undefined opcode.
    function automatic opcode_e decode_op(input logic [OP_W-1:0] raw);
        case (raw)
            4'h1:    return OP_ADD;
            4'h2:    return OP_SUB;
            4'h3:    return OP_AND;
            4'h4:    return OP_OR;
            4'h5:    return OP_LDI;
            4'h6:    return OP_JMP;
            4'h7:    return OP_JZ;
            4'hF:    return OP_HALT;
            default: return OP_NOP;
        endcase
    endfunction

    function automatic logic is_alu(input opcode_e op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
    endfunction

    function automatic logic writes_rf(input opcode_e op);
        return is_alu(op) || (op == OP_LDI);
    endfunction

    function automatic alu_op_e alu_op_of(input opcode_e op);
        alu_op_e f;
        f = ALU_ADD;
        unique case (1'b1)
            op == OP_SUB: f = ALU_SUB;
            op == OP_AND: f = ALU_AND;
            op == OP_OR:  f = ALU_OR;
            op == OP_LDI: f = ALU_PASSB;
            default:      f = ALU_ADD;
        endcase
        return f;
    endfunction

    function automatic logic [RET_W-1:0] sat_inc(input logic [RET_W-1:0] v);
        return (v == {RET_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cpu_ctrl_pc.sv
// Program counter: async clear on reset, sync clear, jump load,
// wrapping increment, otherwise hold.
module cpu_pc
    import cpu_ctrl_pkg::*;
#(
    parameter int AWIDTH = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    input  logic              load,
    input  logic [AWIDTH-1:0] load_val,
    output logic [AWIDTH-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (clr) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + AWIDTH'(1);
        end
    end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle control sequencer for a 16-bit accumulator-style core:
// FETCH/DECODE/EXEC/WB with a terminal HALT state.
module cpu_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_in,
    input  logic [DWIDTH-1:0] ir_in,
    input  logic              alu_zero,
    output logic              rom_en,
    output logic [AWIDTH-1:0] rom_addr,
    output logic [1:0]        rf_ra0,
    output logic [1:0]        rf_ra1,
    output logic              rf_we,
    output logic [1:0]        rf_wa,
    output logic [2:0]        alu_op,
    output logic              imm_sel,
    output logic [7:0]        imm,
    output logic              halted,
    output logic [15:0]       retired
);

    state_e            state;
    logic [DWIDTH-1:0] ir_q;
    logic              z_q;
    ir_t               ir;
    opcode_e           op;
    logic [AWIDTH-1:0] pc;
    logic              pc_inc;
    logic              pc_load;
    logic              taken;

    assign ir = ir_t'(ir_q[15:0]);
    assign op = decode_op(ir.op);

    assign taken   = (op == OP_JMP) || ((op == OP_JZ) && z_q);
    assign pc_inc  = (state == S_DECODE);
    assign pc_load = (state == S_EXEC) && taken;

    cpu_pc #(
        .AWIDTH(AWIDTH)
    ) u_pc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (1'b0),
        .inc     (pc_inc),
        .load    (pc_load),
        .load_val(AWIDTH'(ir.imm)),
        .pc      (pc)
    );

    // The fetch strobe must follow en_in in the same cycle so a stop
    // request in FETCH never issues a ROM read.
    assign rom_en   = (state == S_FETCH) && en_in;
    assign rom_addr = pc;

    // All selects come straight from the IR, which only changes in DECODE,
    // so they stay stable across EXEC and WB.
    assign rf_ra0  = ir.rd;
    assign rf_ra1  = ir.rs;
    assign rf_wa   = ir.rd;
    assign imm     = ir.imm;
    assign alu_op  = alu_op_of(op);
    assign imm_sel = (op == OP_LDI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            ir_q    <= '0;
            z_q     <= 1'b0;
            retired <= '0;
            halted  <= 1'b0;
            rf_we   <= 1'b0;
        end else begin
            rf_we <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (en_in) state <= S_FETCH;
                end
                S_FETCH: begin
                    state <= en_in ? S_DECODE : S_IDLE;
                end
                S_DECODE: begin
                    ir_q  <= ir_in;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (writes_rf(op)) begin
                        rf_we <= 1'b1;
                        state <= S_WB;
                    end else if (op == OP_HALT) begin
                        retired <= sat_inc(retired);
                        halted  <= 1'b1;
                        state   <= S_HALT;
                    end else begin
                        retired <= sat_inc(retired);
                        state   <= S_FETCH;
                    end
                end
                S_WB: begin
                    if (is_alu(op)) z_q <= alu_zero;
                    retired <= sat_inc(retired);
                    state   <= S_FETCH;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Bench for cpu_ctrl: ROM and register-file datapath around the DUT,
// directed scenarios plus random programs against an ISA-level model.
module tb_cpu_ctrl;
    import cpu_ctrl_pkg::*;

    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en_in = 1'b0;
    logic [DW-1:0] ir_in = '0;
    logic          alu_zero;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [1:0]    rf_ra0, rf_ra1, rf_wa;
    logic          rf_we;
    logic [2:0]    alu_op;
    logic          imm_sel;
    logic [7:0]    imm;
    logic          halted;
    logic [15:0]   retired;

    cpu_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .en_in(en_in), .ir_in(ir_in),
        .alu_zero(alu_zero), .rom_en(rom_en), .rom_addr(rom_addr),
        .rf_ra0(rf_ra0), .rf_ra1(rf_ra1), .rf_we(rf_we), .rf_wa(rf_wa),
        .alu_op(alu_op), .imm_sel(imm_sel), .imm(imm),
        .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [15:0] rom [4096];
    logic [15:0] regs [4];
    logic [15:0] pre [4];
    logic        prep = 1'b0;
    logic [15:0] alu_b, alu_res;

    always @(posedge clk) if (rom_en) ir_in <= rom[rom_addr];

    always_comb begin
        alu_b = imm_sel ? {8'h00, imm} : regs[rf_ra1];
        alu_res = 16'h0;
        case (alu_op)
            3'd0: alu_res = regs[rf_ra0] + alu_b;
            3'd1: alu_res = regs[rf_ra0] - alu_b;
            3'd2: alu_res = regs[rf_ra0] & alu_b;
            3'd3: alu_res = regs[rf_ra0] | alu_b;
            3'd4: alu_res = alu_b;
            default: alu_res = 16'h0;
        endcase
        alu_zero = (alu_res == 16'h0);
    end

    always @(posedge clk) begin
        if (prep) regs <= pre;
        else if (rf_we) regs[rf_wa] <= alu_res;
    end

    int            cyc = 0;
    logic [AW-1:0] fetches [$];
    int            we_cyc [$];
    int            we_cnt = 0;
    int            busy = 0;
    logic          started = 1'b0;
    logic          addr1_hit = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (prep) begin
            fetches.delete();
            we_cyc.delete();
            we_cnt = 0;
            busy = 0;
            started = 1'b0;
            addr1_hit = 1'b0;
        end else begin
            if (rom_en) begin
                fetches.push_back(rom_addr);
                started = 1'b1;
                if (rom_addr == 12'd1) addr1_hit = 1'b1;
            end
            if (started && !halted) busy++;
            if (rf_we) begin
                we_cnt++;
                we_cyc.push_back(cyc);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ins(input logic [3:0] o,
        input logic [1:0] rd, input logic [1:0] rs, input logic [7:0] im);
        return {o, rd, rs, im};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) rom[i] = 16'h0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en_in = 1'b0;
        prep = 1'b1;
        repeat (2) @(negedge clk);
        prep = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic run_to_halt(input string tag, input int budget);
        en_in = 1'b1;
        for (int i = 0; i < budget && !halted; i++) @(negedge clk);
        chk(tag, halted, 1'b1);
    endtask

    // ISA-level reference: interpret the ROM instruction by instruction.
    logic [15:0] m_regs [4];
    logic [AW-1:0] m_fetch [$];
    logic [AW-1:0] m_pc;
    int m_cycles, m_writes, m_retired;

    task automatic model_run();
        logic z;
        logic [15:0] w, a, b, r;
        int o;
        m_regs = pre;
        m_fetch.delete();
        m_pc = '0;
        z = 1'b0;
        m_cycles = 0;
        m_writes = 0;
        m_retired = 0;
        for (int s = 0; s < 2000; s++) begin
            w = rom[m_pc];
            m_fetch.push_back(m_pc);
            m_pc = m_pc + 1'b1;
            o = int'(w[15:12]);
            a = m_regs[w[11:10]];
            b = m_regs[w[9:8]];
            m_retired++;
            if (o >= 1 && o <= 5) begin
                if (o == 1) r = a + b;
                else if (o == 2) r = a - b;
                else if (o == 3) r = a & b;
                else if (o == 4) r = a | b;
                else r = {8'h00, w[7:0]};
                if (o != 5) z = (r == 16'h0);
                m_regs[w[11:10]] = r;
                m_writes++;
                m_cycles += 4;
            end else begin
                m_cycles += 3;
                if (o == 6 || (o == 7 && z)) m_pc = AW'(w[7:0]);
                if (o == 15) break;
            end
        end
    endtask

    task automatic compare_model(input string tag);
        int mism;
        mism = 0;
        for (int r = 0; r < 4; r++)
            chk($sformatf("%s_x%0d", tag, r), regs[r], m_regs[r]);
        chk({tag, "_retired"}, retired, m_retired);
        chk({tag, "_pc"}, rom_addr, m_pc);
        chk({tag, "_writes"}, we_cnt, m_writes);
        chk({tag, "_cycles"}, busy, m_cycles);
        chk({tag, "_ntrace"}, fetches.size(), m_fetch.size());
        if (fetches.size() == m_fetch.size())
            foreach (m_fetch[i]) if (fetches[i] !== m_fetch[i]) mism++;
        chk({tag, "_trace"}, mism, 0);
    endtask

    initial begin
        int snap_f, snap_w;
        pre = '{16'h0, 16'h0, 16'h0, 16'h0};
        clear_rom();

        // Reset state
        do_reset();
        #1;
        chk("reset_outs", {rom_en, rf_we, rf_wa, rf_ra0, rf_ra1, alu_op,
                           imm_sel, imm, halted}, 0);
        chk("reset_addr", rom_addr, 0);
        chk("reset_retired", retired, 0);

        // Two dependent ADDs
        clear_rom();
        pre = '{16'd2, 16'd3, 16'd0, 16'd0};
        rom[0] = ins(OP_ADD, 2'd1, 2'd0, 8'h00);
        rom[1] = ins(OP_ADD, 2'd0, 2'd1, 8'h00);
        rom[2] = ins(OP_HALT, 2'd0, 2'd0, 8'h00);
        do_reset();
        en_in = 1'b1;
        for (int i = 0; i < 40 && we_cnt < 2; i++) @(negedge clk);
        chk("add_retired2", retired, 16'd2);
        chk("add_x1", regs[1], 16'd5);
        chk("add_x0", regs[0], 16'd7);
        chk("add_we_gap", (we_cyc.size() == 2) ? we_cyc[1] - we_cyc[0] : 0, 4);
        run_to_halt("add_halt", 40);
        chk("add_retired3", retired, 16'd3);

        // LDI then HALT; halt is terminal
        clear_rom();
        pre = '{16'h0, 16'h0, 16'hAAAA, 16'h0};
        rom[0] = ins(OP_LDI, 2'd2, 2'd0, 8'h7F);
        rom[1] = ins(OP_HALT, 2'd0, 2'd0, 8'h00);
        do_reset();
        run_to_halt("ldi_halt", 40);
        chk("ldi_x2", regs[2], 16'h007F);
        chk("ldi_pc", rom_addr, 2);
        snap_f = fetches.size();
        snap_w = we_cnt;
        for (int i = 0; i < 10; i++) begin
            en_in = i[0];
            @(negedge clk);
        end
        chk("halt_no_fetch", fetches.size(), snap_f);
        chk("halt_no_we", we_cnt, snap_w);
        chk("halt_pc", rom_addr, 2);
        chk("halt_flag", halted, 1'b1);

        // JMP over address 1
        clear_rom();
        pre = '{16'h0, 16'h0, 16'h0, 16'h0};
        rom[0]     = ins(OP_JMP, 2'd0, 2'd0, 8'h10);
        rom[1]     = ins(OP_LDI, 2'd3, 2'd0, 8'hEE);
        rom[16]    = ins(OP_LDI, 2'd3, 2'd0, 8'h01);
        rom[17]    = ins(OP_HALT, 2'd0, 2'd0, 8'h00);
        do_reset();
        run_to_halt("jmp_halt", 60);
        chk("jmp_skip1", addr1_hit, 1'b0);
        chk("jmp_x3", regs[3], 16'd1);
        chk("jmp_target", (fetches.size() > 1) ? fetches[1] : 12'hEEE, 12'h010);

        // JZ taken after zero SUB
        clear_rom();
        pre = '{16'd5, 16'h0, 16'h0, 16'h0};
        rom[0]  = ins(OP_SUB, 2'd0, 2'd0, 8'h00);
        rom[1]  = ins(OP_JZ, 2'd0, 2'd0, 8'h20);
        rom[2]  = ins(OP_HALT, 2'd0, 2'd0, 8'h00);
        rom[32] = ins(OP_HALT, 2'd0, 2'd0, 8'h00);
        do_reset();
        run_to_halt("jz_t_halt", 60);
        chk("jz_t_fetch", (fetches.size() > 2) ? fetches[2] : 12'hEEE, 12'h020);
        chk("jz_t_pc", rom_addr, 12'h021);

        // JZ not taken after nonzero ADD
        pre = '{16'd1, 16'h0, 16'h0, 16'h0};
        do_reset();
        rom[0] = ins(OP_ADD, 2'd0, 2'd0, 8'h00);
        run_to_halt("jz_n_halt", 60);
        chk("jz_n_fetch", (fetches.size() > 2) ? fetches[2] : 12'hEEE, 12'h002);
        chk("jz_n_pc", rom_addr, 12'h003);
        chk("jz_n_x0", regs[0], 16'd2);

        // en_in dropped during EXEC
        clear_rom();
        pre = '{16'd2, 16'd3, 16'h0, 16'h0};
        rom[0] = ins(OP_ADD, 2'd1, 2'd0, 8'h00);
        rom[1] = ins(OP_HALT, 2'd0, 2'd0, 8'h00);
        do_reset();
        en_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("exec_sel", {rf_ra0, rf_ra1, alu_op, imm_sel}, {2'd1, 2'd0, 3'd0, 1'b0});
        en_in = 1'b0;
        @(negedge clk);
        chk("wb_we", rf_we, 1'b1);
        chk("wb_sel", {rf_wa, rf_ra0, rf_ra1}, {2'd1, 2'd1, 2'd0});
        repeat (8) @(negedge clk);
        chk("stop_x1", regs[1], 16'd5);
        chk("stop_nfetch", fetches.size(), 1);
        chk("stop_idle", {rom_en, rf_we, halted}, 3'b000);
        chk("stop_retired", retired, 16'd1);
        run_to_halt("stop_resume", 40);
        chk("stop_next", (fetches.size() > 1) ? fetches[1] : 12'hEEE, 12'h001);

        // Reset during EXEC
        pre = '{16'd2, 16'd3, 16'h0, 16'h0};
        do_reset();
        en_in = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_exec_outs", {rom_en, rf_we, rf_wa, rf_ra0, rf_ra1, alu_op,
                              imm_sel, imm, halted}, 0);
        chk("rst_exec_retired", retired, 0);
        repeat (3) @(negedge clk);
        chk("rst_exec_no_we", we_cnt, 0);
        chk("rst_exec_x1", regs[1], 16'd3);
        rst_n = 1'b1;
        run_to_halt("rst_exec_halt", 40);
        chk("rst_exec_restart", (fetches.size() > 1) ? fetches[1] : 12'hEEE, 12'h000);
        chk("rst_exec_x1b", regs[1], 16'd5);

        // PC wrap 0xFFF -> 0x000 through NOPs
        clear_rom();
        do_reset();
        en_in = 1'b1;
        for (int i = 0; i < 13000 && fetches.size() < 4097; i++) @(negedge clk);
        chk("wrap_reached", fetches.size() >= 4097, 1'b1);
        chk("wrap_fff", (fetches.size() > 4095) ? fetches[4095] : 12'h0, 12'hFFF);
        chk("wrap_000", (fetches.size() > 4096) ? fetches[4096] : 12'hEEE, 12'h000);
        chk("wrap_retired", retired, 16'd4096);
        en_in = 1'b0;

        // Random programs, forward-only jumps ending in HALT
        for (int t = 0; t < 8; t++) begin
            int len;
            logic [3:0] o;
            clear_rom();
            len = 24;
            for (int r = 0; r < 4; r++) pre[r] = 16'($urandom_range(0, 3));
            for (int a = 0; a < len - 1; a++) begin
                o = 4'($urandom_range(0, 14));
                rom[a] = ins(o, 2'($urandom), 2'($urandom), 8'($urandom));
                if (o == 4'h6 || o == 4'h7)
                    rom[a][7:0] = 8'($urandom_range(len - 1, a + 1));
            end
            rom[len - 1] = ins(OP_HALT, 2'd0, 2'd0, 8'h00);
            model_run();
            do_reset();
            run_to_halt($sformatf("rnd%0d_halt", t), 200);
            compare_model($sformatf("rnd%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
